imem_port_arbiter: RTL and testbench

//  Shares the single-port synchronous instruction memory between the fetch stage (reads) and the

---
 rtl/imem_port_arbiter.sv | 60 ++++++
 tb/tb_imem_port_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares the single-port instruction memory between fetch reads and loader writes
module imem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic                  fetch_flush,
  output logic                  fetch_gnt,
  output logic                  fetch_stall,
  output logic                  fetch_rvalid,
  output logic [DATA_WIDTH-1:0] fetch_rdata,
  input  logic                  ld_lock,
  input  logic                  ld_req,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_wdata,
  output logic                  ld_gnt,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  typedef enum logic {RUN, LOCK} state_t;
  state_t     state;
  logic [3:0] burst_cnt;
  logic       rd_inflight, kill, starved;
  assign starved = fetch_req && burst_cnt == 4'(MAX_BURST);
  // grants are forced low while rst is held so nothing issues mid-reset
  assign ld_gnt       = !rst && ld_req && (state == LOCK || !starved);
  assign fetch_gnt    = !rst && state == RUN && fetch_req && !ld_gnt;
  assign fetch_stall  = fetch_req && !fetch_gnt;
  assign fetch_rvalid = rd_inflight && !kill && !fetch_flush;
  assign fetch_rdata  = mem_rdata;
  assign mem_en       = fetch_gnt || ld_gnt;
  assign mem_we       = ld_gnt;
  assign mem_addr     = ld_gnt ? ld_addr : fetch_gnt ? fetch_addr : '0;
  assign mem_wdata    = ld_gnt ? ld_wdata : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      burst_cnt   <= '0;
      rd_inflight <= 1'b0;
      kill        <= 1'b0;
    end else begin
      rd_inflight <= fetch_gnt;
      kill        <= fetch_flush && fetch_gnt;
      if (state == RUN) begin
        state     <= ld_lock ? LOCK : RUN;
        burst_cnt <= (fetch_gnt || !fetch_req) ? 4'd0 :
                     (ld_gnt && burst_cnt != 4'(MAX_BURST)) ? burst_cnt + 4'd1 : burst_cnt;
      end else begin
        state <= (!ld_lock && !ld_req) ? RUN : LOCK;
      end
    end
  end
endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: directed vector table plus reset-mid-read sequence for imem_port_arbiter
module tb_imem_port_arbiter;
  logic        clk = 0, rst = 1;
  logic        fetch_req = 0, fetch_flush = 0, ld_lock = 0, ld_req = 0;
  logic [31:0] fetch_addr = 0, ld_addr = 0, ld_wdata = 0;
  logic        fetch_gnt, fetch_stall, fetch_rvalid, ld_gnt, mem_en, mem_we;
  logic [31:0] fetch_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [256];
  int checks = 0, failures = 0;

  imem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_flush(fetch_flush),
    .fetch_gnt(fetch_gnt), .fetch_stall(fetch_stall), .fetch_rvalid(fetch_rvalid),
    .fetch_rdata(fetch_rdata), .ld_lock(ld_lock), .ld_req(ld_req), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_gnt(ld_gnt), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  // synchronous single-port memory, one-cycle read latency
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    else if (mem_en) mem_rdata <= mem[mem_addr[9:2]];
  end

  typedef struct {
    logic fr; logic [31:0] fa; logic ff, lk, lr; logic [31:0] la, lw;
    logic fg, fs, rv, lg, en, we; logic [31:0] ma, rd;
  } vec_t;
  vec_t vq[$];

  function automatic void add(logic fr, logic [31:0] fa, logic ff, logic lk, logic lr,
                              logic [31:0] la, logic [31:0] lw, logic fg, logic fs, logic rv,
                              logic lg, logic en, logic we, logic [31:0] ma, logic [31:0] rd);
    vq.push_back('{fr, fa, ff, lk, lr, la, lw, fg, fs, rv, lg, en, we, ma, rd});
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000 + i;
    mem_rdata = 0;
    //  fr fa     ff lk lr la     lw      fg fs rv lg en we ma     rd
    add(0, 0,     0, 0, 0, 0,     0,      0, 0, 0, 0, 0, 0, 0,     0);
    add(1, 0,     0, 0, 0, 0,     0,      1, 0, 0, 0, 1, 0, 0,     0);
    add(1, 4,     0, 0, 0, 0,     0,      1, 0, 1, 0, 1, 0, 4,     'h1000);
    add(1, 8,     0, 0, 0, 0,     0,      1, 0, 1, 0, 1, 0, 8,     'h1001);
    add(0, 0,     0, 0, 0, 0,     0,      0, 0, 1, 0, 0, 0, 0,     'h1002);
    for (int i = 0; i < 4; i++)
      add(1, 'h40, 0, 0, 1, 'h80, 'hAA, 0, 1, 0, 1, 1, 1, 'h80, 0);
    add(1, 'h40,  0, 0, 1, 'h80,  'hAA,   1, 0, 0, 0, 1, 0, 'h40,  0);
    add(1, 'h40,  0, 0, 1, 'h80,  'hAA,   0, 1, 1, 1, 1, 1, 'h80,  'h1010);
    add(1, 'h40,  0, 0, 1, 'h80,  'hAA,   0, 1, 0, 1, 1, 1, 'h80,  0);
    add(0, 0,     0, 0, 1, 'h80,  'hAA,   0, 0, 0, 1, 1, 1, 'h80,  0);
    add(1, 'h10,  1, 0, 0, 0,     0,      1, 0, 0, 0, 1, 0, 'h10,  0);
    add(1, 'h14,  0, 0, 0, 0,     0,      1, 0, 0, 0, 1, 0, 'h14,  0);
    add(0, 0,     0, 0, 0, 0,     0,      0, 0, 1, 0, 0, 0, 0,     'h1005);
    add(1, 'h18,  0, 0, 0, 0,     0,      1, 0, 0, 0, 1, 0, 'h18,  0);
    add(0, 0,     1, 0, 0, 0,     0,      0, 0, 0, 0, 0, 0, 0,     0);
    add(0, 0,     1, 0, 0, 0,     0,      0, 0, 0, 0, 0, 0, 0,     0);
    add(0, 0,     0, 0, 0, 0,     0,      0, 0, 0, 0, 0, 0, 0,     0);
    add(0, 0,     0, 1, 0, 0,     0,      0, 0, 0, 0, 0, 0, 0,     0);
    add(1, 'h20,  0, 1, 1, 'h20,  'h13,   0, 1, 0, 1, 1, 1, 'h20,  0);
    add(1, 'h20,  0, 0, 1, 'h24,  'h99,   0, 1, 0, 1, 1, 1, 'h24,  0);
    add(1, 'h20,  0, 0, 0, 0,     0,      0, 1, 0, 0, 0, 0, 0,     0);
    add(1, 'h20,  0, 0, 0, 0,     0,      1, 0, 0, 0, 1, 0, 'h20,  0);
    add(0, 0,     0, 0, 0, 0,     0,      0, 0, 1, 0, 0, 0, 0,     'h13);
    add(1, 'h30,  0, 0, 1, 'h30,  'h55,   0, 1, 0, 1, 1, 1, 'h30,  0);
    add(1, 'h30,  0, 0, 0, 0,     0,      1, 0, 0, 0, 1, 0, 'h30,  0);
    add(0, 0,     0, 0, 0, 0,     0,      0, 0, 1, 0, 0, 0, 0,     'h55);
    add(1, 'h0C,  0, 0, 0, 0,     0,      1, 0, 0, 0, 1, 0, 'h0C,  0);
    add(0, 0,     0, 1, 0, 0,     0,      0, 0, 1, 0, 0, 0, 0,     'h1003);
    add(0, 0,     0, 0, 0, 0,     0,      0, 0, 0, 0, 0, 0, 0,     0);
    add(0, 0,     0, 0, 0, 0,     0,      0, 0, 0, 0, 0, 0, 0,     0);

    repeat (2) @(posedge clk);
    #1 rst = 0;
    foreach (vq[i]) begin
      {fetch_req, fetch_addr, fetch_flush, ld_lock, ld_req, ld_addr, ld_wdata} =
        {vq[i].fr, vq[i].fa, vq[i].ff, vq[i].lk, vq[i].lr, vq[i].la, vq[i].lw};
      @(negedge clk);
      chk($sformatf("v%0d flags{fg,fs,rv,lg,en,we}", i),
          32'({fetch_gnt, fetch_stall, fetch_rvalid, ld_gnt, mem_en, mem_we}),
          32'({vq[i].fg, vq[i].fs, vq[i].rv, vq[i].lg, vq[i].en, vq[i].we}));
      chk($sformatf("v%0d mem_addr", i), mem_addr, vq[i].ma);
      chk($sformatf("v%0d mem_wdata", i), mem_wdata, vq[i].lg ? vq[i].lw : 32'd0);
      if (vq[i].rv) chk($sformatf("v%0d fetch_rdata", i), fetch_rdata, vq[i].rd);
      @(posedge clk);
      #1;
    end

    // asynchronous reset while a read is in flight
    fetch_req = 1; fetch_addr = 'h04;
    @(negedge clk);
    chk("rst_pre fetch_gnt", 32'(fetch_gnt), 1);
    @(posedge clk);
    #2;
    chk("rst_pre rvalid", 32'(fetch_rvalid), 1);
    ld_req = 1; ld_addr = 'h04; ld_wdata = 'hDEAD;
    rst = 1;
    #1;
    chk("rst_mid {fg,lg,rv,en}", 32'({fetch_gnt, ld_gnt, fetch_rvalid, mem_en}), 0);
    @(posedge clk);
    #1 ld_req = 0; fetch_req = 0;
    rst = 0;
    fetch_req = 1; fetch_addr = 0;
    @(negedge clk);
    chk("post_rst fetch_gnt", 32'(fetch_gnt), 1);
    chk("post_rst rvalid", 32'(fetch_rvalid), 0);
    @(posedge clk);
    #1 fetch_req = 0;
    @(negedge clk);
    chk("post_rst rvalid2", 32'(fetch_rvalid), 1);
    chk("post_rst rdata", fetch_rdata, 'h1000);
    chk("post_rst no write retry", mem[1], 'h1001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
